muldiv_ctrl: RTL and testbench

Sequencer that sits between the EX stage and the iterative multiply and divide units. It owns the HI/LO architectural registers and decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO. It launches the proper unit with a level start/ready handshake, stalls the pipeline until the result lands, and cancels in-flight work on flush. One instruction is in service at a time; HI/LO update exactly once per retired instruction.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_ctrl_hilo_regs.sv | 30 +++
 rtl/muldiv_ctrl.sv | 134 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings for the HI/LO multiply-divide sequencer
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  function automatic logic is_mul(input op_e o);
    return (o == OP_MULT) || (o == OP_MULTU);
  endfunction

  function automatic logic is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// rtl/muldiv_ctrl_hilo_regs.sv - architectural HI/LO pair with single-word and joint write ports
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               joint_we,
  input  logic [2*WIDTH-1:0] joint_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  // Joint result writes and MTHI/MTLO are mutually exclusive by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (joint_we) begin
      hi <= joint_data[2*WIDTH-1:WIDTH];
      lo <= joint_data[WIDTH-1:0];
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage sequencer for iterative multiply/divide units and HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  input  logic               pipe_stall,
  output logic               stall_req,
  output logic               mul_start,
  output logic               mul_signed,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_annul,
  input  logic               mul_ready,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               div_start,
  output logic               div_signed,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  output logic               div_annul,
  input  logic               div_ready,
  input  logic [2*WIDTH-1:0] div_result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy
);

  state_e state;
  op_e    opc;
  logic   accept;
  logic   b_zero;
  logic   mul_commit;
  logic   div_commit;
  logic   hi_we;
  logic   lo_we;

  assign opc        = op_e'(op);
  assign accept     = (state == ST_IDLE) && op_valid && !flush;
  assign b_zero     = (src_b == '0);
  assign busy       = (state == ST_MUL_BUSY) || (state == ST_DIV_BUSY);
  assign stall_req  = (accept && (is_mul(opc) || (is_div(opc) && !b_zero))) || busy;
  assign hi_we      = accept && (opc == OP_MTHI);
  assign lo_we      = accept && (opc == OP_MTLO);
  // A flush in the same cycle as ready wins: the result is discarded.
  assign mul_commit = (state == ST_MUL_BUSY) && !flush && mul_ready;
  assign div_commit = (state == ST_DIV_BUSY) && !flush && div_ready;

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk        (clk),
    .rst        (rst),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (src_a),
    .joint_we   (mul_commit || div_commit),
    .joint_data (mul_commit ? mul_result : div_result),
    .hi         (hi),
    .lo         (lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mul_start  <= 1'b0;
      mul_signed <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_annul  <= 1'b0;
      div_start  <= 1'b0;
      div_signed <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_annul  <= 1'b0;
    end else begin
      mul_annul <= 1'b0;
      div_annul <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul(opc)) begin
              mul_a      <= src_a;
              mul_b      <= src_b;
              mul_signed <= (opc == OP_MULT);
              mul_start  <= 1'b1;
              state      <= ST_MUL_BUSY;
            end else if (is_div(opc)) begin
              // Divide by zero retires without launching; HI/LO stay as they are.
              if (b_zero) begin
                state <= ST_DONE;
              end else begin
                div_a      <= src_a;
                div_b      <= src_b;
                div_signed <= (opc == OP_DIV);
                div_start  <= 1'b1;
                state      <= ST_DIV_BUSY;
              end
            end
          end
        end
        ST_MUL_BUSY: begin
          if (flush) begin
            mul_annul <= 1'b1;
            mul_start <= 1'b0;
            state     <= ST_IDLE;
          end else if (mul_ready) begin
            mul_start <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DIV_BUSY: begin
          if (flush) begin
            div_annul <= 1'b1;
            div_start <= 1'b0;
            state     <= ST_IDLE;
          end else if (div_ready) begin
            div_start <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush || !pipe_stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with behavioural mul/div units
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        pipe_stall = 1'b0;
  logic        stall_req;
  logic        mul_start, mul_signed, mul_annul, mul_ready;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_a, div_b;
  logic [63:0] div_result;
  logic [31:0] hi, lo;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    int          starts;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  int   mul_delay = 1;
  int   div_delay = 1;
  int   mul_cnt, div_cnt;
  logic force_mul_ready = 1'b0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .pipe_stall(pipe_stall),
    .stall_req(stall_req),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_annul(mul_annul), .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .hi(hi), .lo(lo), .busy(busy)
  );

  // Units count cycles of start; ready asserts during the delay-th start cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt <= 0;
      div_cnt <= 0;
    end else begin
      mul_cnt <= mul_start ? mul_cnt + 1 : 0;
      div_cnt <= div_start ? div_cnt + 1 : 0;
    end
  end
  assign mul_ready = force_mul_ready || (mul_start && (mul_cnt >= mul_delay - 1));
  assign div_ready = div_start && (div_cnt >= div_delay - 1);

  function automatic logic [63:0] mul_unit(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(x * y);
  endfunction

  function automatic logic [63:0] div_unit(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (y == 0) return 64'd0;
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  assign mul_result = mul_unit(mul_signed, mul_a, mul_b);
  assign div_result = div_unit(div_signed, div_a, div_b);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: architectural effect of one instruction, from the ISA rules.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      3'd1: begin p = 64'(sa * sbv); {m_hi, m_lo} = p; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'd3: if (b != 0) begin m_lo = 32'(sa / sbv); m_hi = 32'(sa % sbv); end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction leaves EX.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int dly, input int hold, input bit kill);
    exp_t e;
    bit   launch, done;
    mul_delay = dly;
    div_delay = dly;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    if (kill) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0;
      return;
    end
    launch = (o >= 3'd1 && o <= 3'd4) && !((o == 3'd3 || o == 3'd4) && b == 0);
    model(o, a, b);
    e.hi = m_hi; e.lo = m_lo;
    e.stalls = launch ? dly + 1 : 0;
    e.starts = launch ? 1 : 0;
    sb.push_back(e);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (!stall_req && hold > 0) begin pipe_stall = 1'b1; hold--; end
      else pipe_stall = 1'b0;
      done = !stall_req && !pipe_stall;
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL issue_timeout op=%0d", o);
    end
    op_valid = 1'b0;
    pipe_stall = 1'b0;
    if (o >= 3'd1 && o <= 3'd4) begin @(posedge clk); #1; end
  endtask

  // Monitor: counts stall cycles and launch episodes, compares HI/LO on retire.
  initial begin
    int   stalls, starts;
    logic prev;
    exp_t e;
    stalls = 0; starts = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalls = 0; starts = 0; prev = 1'b0;
      end else begin
        if ((mul_start || div_start) && !prev) starts++;
        prev = mul_start || div_start;
        if (op_valid && flush) begin
          stalls = 0; starts = 0;
        end else if (op_valid) begin
          if (stall_req) stalls++;
          else if (!pipe_stall) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
              errors++; checks++;
              $display("FAIL retire_unexpected got=1 exp=0");
            end else begin
              e = sb.pop_front();
              chk("hi", hi, e.hi);
              chk("lo", lo, e.lo);
              chk("stall_cycles", stalls, e.stalls);
              chk("start_episodes", starts, e.starts);
            end
            stalls = 0; starts = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b, sh, sl;
    logic [2:0]  o;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_annul", {mul_annul, div_annul}, 0);
    chk("rst_signed", {mul_signed, div_signed}, 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_stall_req", stall_req, 0);

    issue(3'd5, 32'h1234_5678, 32'h0, 1, 0, 0);
    issue(3'd6, 32'h9ABC_DEF0, 32'h0, 1, 0, 0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1, 0, 0);
    chk("mul_signed_mult", mul_signed, 1);
    issue(3'd4, 32'd100, 32'd7, 4, 0, 0);
    issue(3'd3, 32'd5, 32'd0, 1, 0, 0);

    // MULTU flushed while in flight, with ready forced in the flush cycle.
    sh = hi; sl = lo;
    mul_delay = 20;
    op_valid = 1'b1; op = 3'd2; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; force_mul_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; force_mul_ready = 1'b0; op_valid = 1'b0;
    chk("flush_annul_pulse", mul_annul, 1);
    chk("flush_start_drop", mul_start, 0);
    chk("flush_busy", busy, 0);
    chk("flush_mul_signed", mul_signed, 0);
    chk("flush_hi", hi, sh);
    chk("flush_lo", lo, sl);
    @(posedge clk); #1;
    chk("flush_annul_end", mul_annul, 0);
    chk("flush_stall_req", stall_req, 0);

    issue(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 1, 3, 0);
    issue(3'd6, 32'h0BAD_F00D, 32'h0, 1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      issue(o, a, b, $urandom_range(1, 6),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset while a multiply is in flight.
    mul_delay = 50;
    op_valid = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_start", mul_start, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_hilo", {hi, lo}, 0);
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
